miter_cmp_arbiter: RTL

- Shares one X-tolerant gold/gate comparator between NREQ requesters. Each requester is a partition miter presenting a gold word and a gate word.
- Requesters are served in round-robin order. The block returns a per-request match result and keeps global statistics: check count, mismatch count, first-failure capture.
- Sits between the partition miters and the equivalence-check reporting logic. It replaces per-partition comparators when there are many partitions.

---
 rtl/miter_cmp_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/miter_cmp_arbiter.sv
// Round-robin arbiter sharing one X-tolerant gold/gate comparator across NREQ partition miters.
// Defining MITER_CMP_ASSERT_EN adds a mismatch assert plus covers for formal flows.
module miter_cmp_arbiter #(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] gold,
  input  logic [NREQ*WIDTH-1:0] gate,
  input  logic                  clr,
  output logic [NREQ-1:0]       ack,
  output logic                  ack_match,
  output logic                  busy,
  output logic                  fail_sticky,
  output logic [IDW-1:0]        fail_id,
  output logic [CNT_W-1:0]      check_cnt,
  output logic [CNT_W-1:0]      mismatch_cnt
);

  typedef enum logic [1:0] {StIdle, StGrant, StCompare, StResp} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_q, sel_q, pick;
  logic [WIDTH-1:0]   g_q, t_q;
  logic               okay_q, cmp_ok, found;
  logic [CNT_W-1:0]   check_cnt_q, mismatch_cnt_q;
  logic               fail_sticky_q;
  logic [IDW-1:0]     fail_id_q;
  logic [WIDTH-1:0]   gold_w [NREQ];
  logic [WIDTH-1:0]   gate_w [NREQ];
  int unsigned        idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign gold_w[i] = gold[i*WIDTH +: WIDTH];
    assign gate_w[i] = gate[i*WIDTH +: WIDTH];
  end

  // First asserted request at or after the round-robin pointer, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_q) + i) % NREQ;
      if (!found && req[IDW'(idx)]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  // Gold X bits are don't-care; a gate X against defined gold never matches.
  always_comb begin
    cmp_ok = 1'b1;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if (!(g_q[b] === 1'bx || g_q[b] === t_q[b])) cmp_ok = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (|req) state_d = StGrant;
      StGrant:   state_d = StCompare;
      StCompare: state_d = StResp;
      StResp:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rr_q    <= '0;
      sel_q   <= '0;
      g_q     <= '0;
      t_q     <= '0;
      okay_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && found) sel_q <= pick;
      if (state_q == StGrant) begin
        g_q <= gold_w[sel_q];
        t_q <= gate_w[sel_q];
      end
      if (state_q == StCompare) okay_q <= cmp_ok;
      if (state_q == StResp) rr_q <= (sel_q == IDW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
    end
  end

  // Clear outranks a coinciding response: the ack still goes out but is not recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      fail_sticky_q  <= 1'b0;
      fail_id_q      <= '0;
    end else if (clr) begin
      check_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      fail_sticky_q  <= 1'b0;
      fail_id_q      <= '0;
    end else if (state_q == StResp) begin
      if (check_cnt_q != '1) check_cnt_q <= check_cnt_q + 1'b1;
      if (!okay_q) begin
        if (mismatch_cnt_q != '1) mismatch_cnt_q <= mismatch_cnt_q + 1'b1;
        if (!fail_sticky_q) begin
          fail_sticky_q <= 1'b1;
          fail_id_q     <= sel_q;
        end
      end
    end
  end

  always_comb begin
    ack       = '0;
    ack_match = 1'b0;
    if (state_q == StResp) begin
      ack[sel_q] = 1'b1;
      ack_match  = okay_q;
    end
  end

  assign busy         = (state_q != StIdle);
  assign fail_sticky  = fail_sticky_q;
  assign fail_id      = fail_id_q;
  assign check_cnt    = check_cnt_q;
  assign mismatch_cnt = mismatch_cnt_q;

`ifdef MITER_CMP_ASSERT_EN
  always @* begin
    if (state_q == StCompare) begin
      assert (cmp_ok);
      cover (!cmp_ok);
    end
    cover (fail_sticky_q);
  end
`endif

endmodule
